fpalu_norm_pack: RTL and testbench

//  Post-normalizer directly downstream of FPALU. Accepts one FPALU result word
//  (sign, 6b exp, 22b left-aligned denorm mantissa) per valid/ready handshake.

---
 rtl/fpalu_norm_pack.sv | 143 ++++++++++++++
 tb/tb_fpalu_norm_pack.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_norm_pack.sv
// Post-normalizer for FPALU results: accepts {sgn, exp, left-aligned mantissa},
// shifts the mantissa left by at most SHIFT_STEP bits per cycle until bit 21 is
// set or the exponent reaches 0, then presents the packed word and flags.
//
// Handshake rules (both ports): a word moves on a rising edge where vld & rdy.
// A producer holds its vld and data stable until that edge; dout_* never
// change while dout_vld & !dout_rdy. din_rdy is high in IDLE, low in NORM,
// follows dout_rdy in DONE so a new word is captured on the same edge the
// result leaves, and is held low while rst is asserted.
module fpalu_norm_pack #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        din_y_sgn,
  input  logic [5:0]  din_y_exp,
  input  logic [21:0] din_y_man_dn,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic [28:0] dout_pkd,
  output logic        dout_zero,
  output logic        dout_sub,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] STEP6 = 6'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [5:0]  exp_q, exp_d;
  logic [21:0] man_q, man_d;

  logic        accept;
  logic        lz_found;
  logic [5:0]  lz;
  logic [5:0]  shamt;
  logic [21:0] man_sh;
  logic [5:0]  exp_sh;

  assign accept = din_vld & din_rdy;

  // Leading-zero count of the working mantissa (22 when it is all zero).
  always_comb begin
    lz       = 6'd22;
    lz_found = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!lz_found && man_q[i]) begin
        lz       = 6'(21 - i);
        lz_found = 1'b1;
      end
    end
  end

  // One normalization step: shift by the smallest of lz, step size and exp so
  // the exponent can never wrap below zero.
  always_comb begin
    shamt = lz;
    if (STEP6 < shamt) shamt = STEP6;
    if (exp_q < shamt) shamt = exp_q;
    man_sh = man_q << shamt;
    exp_sh = exp_q - shamt;
  end

  // State and working registers; reset drops any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sgn_q   <= 1'b0;
      exp_q   <= 6'd0;
      man_q   <= 22'd0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
    end
  end

  // Next state and working-register updates (capture, shift, release).
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    exp_d   = exp_q;
    man_d   = man_q;
    if (accept) begin
      sgn_d = din_y_sgn;
      if (din_y_man_dn == 22'd0) begin
        exp_d   = 6'd0;
        man_d   = 22'd0;
        state_d = ST_DONE;
      end else begin
        exp_d = din_y_exp;
        man_d = din_y_man_dn;
        if (din_y_man_dn[21] || din_y_exp == 6'd0) state_d = ST_DONE;
        else                                       state_d = ST_NORM;
      end
    end else begin
      case (state_q)
        ST_NORM: begin
          man_d = man_sh;
          exp_d = exp_sh;
          if (man_sh[21] || exp_sh == 6'd0) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (dout_rdy) state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Port outputs decoded from the state and working registers.
  always_comb begin
    din_rdy   = 1'b0;
    dout_vld  = 1'b0;
    dout_pkd  = 29'd0;
    dout_zero = 1'b0;
    dout_sub  = 1'b0;
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
    case (state_q)
      ST_IDLE: din_rdy = ~rst;
      ST_DONE: begin
        din_rdy   = dout_rdy & ~rst;
        dout_vld  = 1'b1;
        dout_pkd  = {sgn_q, exp_q, man_q};
        dout_zero = (man_q == 22'd0);
        dout_sub  = (man_q != 22'd0) && (exp_q == 6'd0) && !man_q[21];
      end
      default: din_rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fpalu_norm_pack.sv
// Bench for fpalu_norm_pack: directed cases followed by random words, each
// compared against a bit-at-a-time normalization model.
module tb_fpalu_norm_pack;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic        din_y_sgn = 1'b0;
  logic [5:0]  din_y_exp = 6'd0;
  logic [21:0] din_y_man_dn = 22'd0;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic [28:0] dout_pkd;
  logic        dout_zero;
  logic        dout_sub;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Scoreboard: expected packed word, flags {zero,sub} and latency.
  logic [28:0] exp_q[$];
  logic [1:0]  exp_flag_q[$];
  int          exp_lat_q[$];

  fpalu_norm_pack #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .din_vld(din_vld), .din_rdy(din_rdy),
    .din_y_sgn(din_y_sgn), .din_y_exp(din_y_exp), .din_y_man_dn(din_y_man_dn),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_pkd(dout_pkd),
    .dout_zero(dout_zero), .dout_sub(dout_sub), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: shift one bit at a time while the word is unnormalized and the
  // exponent is positive; latency counts one capture cycle plus step cycles.
  task automatic model(input logic s, input logic [5:0] e, input logic [21:0] m,
                       output logic [28:0] pkd, output logic [1:0] flags, output int lat);
    int n = 0;
    int ee = e;
    logic [21:0] mm = m;
    if (mm == 22'd0) ee = 0;
    else begin
      while (!mm[21] && ee > 0) begin
        mm = mm << 1;
        ee--;
        n++;
      end
    end
    pkd   = {s, 6'(ee), mm};
    flags = {mm == 22'd0, (mm != 22'd0) && (ee == 0) && !mm[21]};
    lat   = 1 + (n + STEP - 1) / STEP;
  endtask

  // Present a word at a negedge; optionally release the pending result on the
  // same edge. Returns just after the capturing edge.
  task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m,
                      input bit release_prev);
    logic [28:0] p;
    logic [1:0]  f;
    int          l;
    model(s, e, m, p, f, l);
    exp_q.push_back(p);
    exp_flag_q.push_back(f);
    exp_lat_q.push_back(l);
    din_y_sgn = s;
    din_y_exp = e;
    din_y_man_dn = m;
    din_vld = 1'b1;
    dout_rdy = release_prev;
    #1;
    check("din_rdy_at_capture", 32'(din_rdy), 32'd1);
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    dout_rdy = 1'b0;
  endtask

  // Count edges (capture edge included) until dout_vld, then compare outputs.
  task automatic wait_result(input string tag);
    logic [28:0] p;
    logic [1:0]  f;
    int          l;
    int          lat = 1;
    p = exp_q.pop_front();
    f = exp_flag_q.pop_front();
    l = exp_lat_q.pop_front();
    @(negedge clk);
    while (!dout_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(l));
    check({tag, "_pkd"}, 32'(dout_pkd), 32'(p));
    check({tag, "_flags"}, 32'({dout_zero, dout_sub}), 32'(f));
  endtask

  task automatic drain();
    dout_rdy = 1'b1;
    @(posedge clk);
    #1;
    dout_rdy = 1'b0;
    @(negedge clk);
    check("drain_vld", 32'(dout_vld), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [28:0] hold_pkd;
    logic [1:0]  hf;
    int          hl;
    bit          pending;
    logic [5:0]  re;
    logic [21:0] rm;

    // Reset state
    #2;
    check("rst_din_rdy", 32'(din_rdy), 32'd0);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkd", 32'(dout_pkd), 32'd0);
    check("rst_flags", 32'({dout_zero, dout_sub}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_din_rdy", 32'(din_rdy), 32'd1);
    @(negedge clk);

    // Directed cases
    send(1'b1, 6'd20, 22'h0F0000, 0); wait_result("normal");
    check("normal_exact", 32'(dout_pkd), 32'({1'b1, 6'd18, 22'h3C0000}));
    drain();
    send(1'b0, 6'd40, 22'h000001, 0); wait_result("long");
    check("long_exact", 32'(dout_pkd), 32'({1'b0, 6'd19, 22'h200000}));
    drain();
    send(1'b0, 6'd3, 22'h000001, 0); wait_result("underflow");
    check("underflow_sub", 32'(dout_sub), 32'd1);
    drain();
    send(1'b1, 6'd33, 22'h000000, 0); wait_result("zero");
    check("zero_exact", 32'(dout_pkd), 32'({1'b1, 6'd0, 22'h0}));
    drain();
    send(1'b0, 6'd5, 22'h200001, 0); wait_result("passthru");
    drain();
    send(1'b0, 6'd0, 22'h000100, 0); wait_result("exp0_in");
    drain();

    // Backpressure then back-to-back capture
    send(1'b1, 6'd30, 22'h001234, 0);
    model(1'b1, 6'd30, 22'h001234, hold_pkd, hf, hl);
    wait_result("bp");
    din_y_sgn = 1'b0; din_y_exp = 6'd9; din_y_man_dn = 22'h0000F0; din_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", 32'(dout_pkd), 32'(hold_pkd));
      check("bp_din_rdy", 32'(din_rdy), 32'd0);
    end
    send(1'b0, 6'd9, 22'h0000F0, 1); wait_result("b2b");
    drain();

    // Reset during NORM
    send(1'b0, 6'd40, 22'h000001, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vld", 32'(dout_vld), 32'd0);
    check("midrst_din_rdy", 32'(din_rdy), 32'd0);
    exp_q.delete(); exp_flag_q.delete(); exp_lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1'b1, 6'd12, 22'h010000, 0); wait_result("after_rst");
    drain();

    // Random words, mixing idle starts and back-to-back captures
    pending = 0;
    for (int i = 0; i < 150; i++) begin
      re = 6'($urandom_range(0, 63));
      rm = 22'($urandom) >> $urandom_range(0, 22);
      if ($urandom_range(0, 15) == 0) rm = 22'd0;
      if (pending && $urandom_range(0, 1) == 1) begin
        send(1'($urandom), re, rm, 1);
      end else begin
        if (pending) drain();
        send(1'($urandom), re, rm, 0);
      end
      wait_result("rand");
      pending = 1;
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
